// File: rtl/mlp_weight_loader.sv
// Byte-stream loader for the MLP parameter set: buffers a 13-byte frame plus checksum
// in shadow registers and commits all values to the outputs in one cycle once the frame checks out.
module mlp_weight_loader #(
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [7:0]        s_data,
   input  logic              s_sof,
   output logic signed [7:0] hidden_weight1,
   output logic signed [7:0] hidden_weight2,
   output logic signed [7:0] hidden_weight3,
   output logic signed [7:0] hidden_weight4,
   output logic signed [7:0] hidden_weight5,
   output logic signed [7:0] hidden_weight6,
   output logic signed [7:0] hidden_bias1,
   output logic signed [7:0] hidden_bias2,
   output logic signed [7:0] hidden_bias3,
   output logic signed [7:0] output_weight1,
   output logic signed [7:0] output_weight2,
   output logic signed [7:0] output_weight3,
   output logic signed [7:0] output_bias,
   output logic              weights_valid,
   output logic              load_done,
   output logic              load_err
);

   localparam int NUM_PARAMS = 13;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_COMMIT
   } state_t;

   state_t     state;
   logic [7:0] shadow [NUM_PARAMS];
   logic [7:0] active [NUM_PARAMS];
   logic [3:0] cnt;
   logic [7:0] sum;
   logic [7:0] idle_cnt;
   logic       xfer;
   logic [7:0] sum_with_byte;

   // COMMIT is the only state that back-pressures the stream.
   assign s_ready       = (state != ST_COMMIT);
   assign xfer          = s_valid && s_ready;
   assign sum_with_byte = sum + s_data;

   // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= ST_IDLE;
         cnt           <= '0;
         sum           <= '0;
         idle_cnt      <= '0;
         weights_valid <= 1'b0;
         load_done     <= 1'b0;
         load_err      <= 1'b0;
         // NOTE: the register arrays are reset too, so a reset mid-frame leaves no stale values anywhere.
         for (int i = 0; i < NUM_PARAMS; i++) begin
            shadow[i] <= '0;
            active[i] <= '0;
         end
      end else begin
         load_done <= 1'b0;
         load_err  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (xfer && s_sof) begin
                  shadow[0] <= s_data;
                  cnt       <= 4'd1;
                  sum       <= s_data;
                  idle_cnt  <= '0;
                  state     <= ST_LOAD;
               end
            end

            ST_LOAD: begin
               if (xfer) begin
                  idle_cnt <= '0;
                  if (s_sof) begin
                     load_err  <= 1'b1;
                     shadow[0] <= s_data;
                     cnt       <= 4'd1;
                     sum       <= s_data;
                  end else if (cnt == 4'(NUM_PARAMS)) begin
                     if (sum_with_byte == 8'h00) begin
                        state <= ST_COMMIT;
                     end else begin
                        load_err <= 1'b1;
                        state    <= ST_IDLE;
                     end
                  end else begin
                     shadow[cnt] <= s_data;
                     cnt         <= cnt + 4'd1;
                     sum         <= sum_with_byte;
                  end
               end else if (idle_cnt == 8'(TIMEOUT - 1)) begin
                  load_err <= 1'b1;
                  state    <= ST_IDLE;
               end else begin
                  idle_cnt <= idle_cnt + 8'd1;
               end
            end

            ST_COMMIT: begin
               for (int i = 0; i < NUM_PARAMS; i++) begin
                  active[i] <= shadow[i];
               end
               weights_valid <= 1'b1;
               load_done     <= 1'b1;
               state         <= ST_IDLE;
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

   // Frame byte order: hw1 hw2 hb1 hw3 hw4 hb2 hw5 hw6 hb3 ow1 ow2 ow3 ob.
   assign hidden_weight1 = active[0];
   assign hidden_weight2 = active[1];
   assign hidden_bias1   = active[2];
   assign hidden_weight3 = active[3];
   assign hidden_weight4 = active[4];
   assign hidden_bias2   = active[5];
   assign hidden_weight5 = active[6];
   assign hidden_weight6 = active[7];
   assign hidden_bias3   = active[8];
   assign output_weight1 = active[9];
   assign output_weight2 = active[10];
   assign output_weight3 = active[11];
   assign output_bias    = active[12];

endmodule
